// File: rtl/usb_ep_multiplexer_if.sv
// Endpoint multiplexer bus bundle: RX packet layer inputs, per-endpoint
// RX/TX outputs and the ULPI transmit path. The multiplexer uses the slave
// view; the surrounding logic (packet layer, endpoint handlers) uses master.
interface usb_ep_multiplexer_if #(
    parameter int NUM_EP = 4,
    parameter int CNT_W  = 16
);
    // RX side
    logic [6:0]          dev_addr;
    logic [23:0]         rx_token;
    logic                rx_token_strb;
    logic [7:0]          rx_data;
    logic                rx_data_strb;
    logic                rx_data_end;
    logic                rx_data_fail;
    logic [7:0]          rx_pid;
    logic [NUM_EP-1:0]   ep_token_strb;
    logic [7:0]          ep_pid;
    logic [7:0]          ep_data;
    logic [NUM_EP-1:0]   ep_data_strb;
    logic [NUM_EP-1:0]   ep_data_end;
    logic [NUM_EP-1:0]   ep_data_fail;
    logic [CNT_W-1:0]    drop_cnt;

    // TX side
    logic [NUM_EP-1:0]   ep_tx_start_stop;
    logic [8*NUM_EP-1:0] ep_tx_data;
    logic [NUM_EP-1:0]   ep_tx_strb;
    logic [NUM_EP-1:0]   ep_tx_fail;
    logic                ulpi_tx_start_stop;
    logic [7:0]          ulpi_tx_data;
    logic                ulpi_tx_strb;
    logic                ulpi_tx_fail;

    modport master (
        output dev_addr, rx_token, rx_token_strb, rx_data, rx_data_strb,
               rx_data_end, rx_data_fail, rx_pid,
               ep_tx_start_stop, ep_tx_data, ulpi_tx_strb, ulpi_tx_fail,
        input  ep_token_strb, ep_pid, ep_data, ep_data_strb, ep_data_end,
               ep_data_fail, drop_cnt, ep_tx_strb, ep_tx_fail,
               ulpi_tx_start_stop, ulpi_tx_data
    );

    modport slave (
        input  dev_addr, rx_token, rx_token_strb, rx_data, rx_data_strb,
               rx_data_end, rx_data_fail, rx_pid,
               ep_tx_start_stop, ep_tx_data, ulpi_tx_strb, ulpi_tx_fail,
        output ep_token_strb, ep_pid, ep_data, ep_data_strb, ep_data_end,
               ep_data_fail, drop_cnt, ep_tx_strb, ep_tx_fail,
               ulpi_tx_start_stop, ulpi_tx_data
    );
endinterface

// File: rtl/usb_ep_multiplexer.sv
// USB endpoint multiplexer.
// RX: decodes tokens for this device, steers the following data packet to
// the addressed endpoint channel, counts packets that had no selection.
// TX: round-robin arbitration of NUM_EP transmit requesters onto the single
// ULPI transmit path.
module usb_ep_multiplexer #(
    parameter int NUM_EP        = 4,
    parameter int TOKEN_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic USB_CLKIN,
    input  logic NRST,
    usb_ep_multiplexer_if.slave bus
);

    localparam logic [1:0] RX_IDLE     = 2'd0;
    localparam logic [1:0] RX_SELECTED = 2'd1;
    localparam logic [1:0] RX_DATA     = 2'd2;

    localparam int TMR_W = (TOKEN_TIMEOUT < 1) ? 1 : $clog2(TOKEN_TIMEOUT + 1);

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    logic [1:0]        rx_state;
    logic [3:0]        sel;
    logic [TMR_W-1:0]  timer;
    logic              dropping;
    logic [NUM_EP-1:0] token_strb_q;
    logic [7:0]        pid_q;
    logic [7:0]        data_q;
    logic [NUM_EP-1:0] data_strb_q;
    logic [NUM_EP-1:0] data_end_q;
    logic [NUM_EP-1:0] data_fail_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic [7:0]        tok_pid;
    logic [6:0]        tok_addr;
    logic [3:0]        tok_endp;
    logic              tok_match;
    logic [NUM_EP-1:0] tok_oh;
    logic [NUM_EP-1:0] sel_oh;
    logic              pkt_evt;
    logic              unused_crc;

    assign tok_pid    = bus.rx_token[7:0];
    assign tok_addr   = bus.rx_token[14:8];
    assign tok_endp   = bus.rx_token[18:15];
    // CRC5 is already checked by the packet layer.
    assign unused_crc = ^bus.rx_token[23:19];
    assign tok_match  = (tok_addr == bus.dev_addr) && (32'(tok_endp) < 32'(NUM_EP));
    assign pkt_evt    = bus.rx_data_strb | bus.rx_data_end | bus.rx_data_fail;

    // One-hot decode of the token endpoint and the current selection.
    always_comb begin
        tok_oh = '0;
        sel_oh = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            tok_oh[i] = (tok_endp == 4'(i));
            sel_oh[i] = (sel == 4'(i));
        end
    end

    // RX FSM: token selection, packet forwarding and drop counting.
    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            rx_state     <= RX_IDLE;
            sel          <= '0;
            timer        <= '0;
            dropping     <= 1'b0;
            token_strb_q <= '0;
            pid_q        <= '0;
            data_q       <= '0;
            data_strb_q  <= '0;
            data_end_q   <= '0;
            data_fail_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            token_strb_q <= '0;
            data_strb_q  <= '0;
            data_end_q   <= '0;
            data_fail_q  <= '0;
            if (bus.rx_token_strb) begin
                // A new token always restarts selection, whatever was in flight.
                dropping <= 1'b0;
                if (tok_match) begin
                    sel          <= tok_endp;
                    rx_state     <= RX_SELECTED;
                    timer        <= TMR_W'(TOKEN_TIMEOUT);
                    token_strb_q <= tok_oh;
                    pid_q        <= tok_pid;
                end else begin
                    sel      <= '0;
                    rx_state <= RX_IDLE;
                end
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        // Only packets that showed data while unselected count as dropped.
                        if ((dropping || bus.rx_data_strb) && (bus.rx_data_end || bus.rx_data_fail)) begin
                            if (drop_cnt_q != '1)
                                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                            dropping <= 1'b0;
                        end else if (bus.rx_data_strb) begin
                            dropping <= 1'b1;
                        end
                    end
                    RX_SELECTED, RX_DATA: begin
                        if (pkt_evt) begin
                            if (rx_state == RX_SELECTED)
                                pid_q <= bus.rx_pid;
                            if (bus.rx_data_strb) begin
                                data_q      <= bus.rx_data;
                                data_strb_q <= sel_oh;
                            end
                            if (bus.rx_data_end) begin
                                data_end_q <= sel_oh;
                                rx_state   <= RX_IDLE;
                            end else if (bus.rx_data_fail) begin
                                data_fail_q <= sel_oh;
                                rx_state    <= RX_IDLE;
                            end else begin
                                rx_state <= RX_DATA;
                            end
                        end else if (rx_state == RX_SELECTED) begin
                            if (timer == '0)
                                rx_state <= RX_IDLE;
                            else
                                timer <= timer - TMR_W'(1);
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign bus.ep_token_strb = token_strb_q;
    assign bus.ep_pid        = pid_q;
    assign bus.ep_data       = data_q;
    assign bus.ep_data_strb  = data_strb_q;
    assign bus.ep_data_end   = data_end_q;
    assign bus.ep_data_fail  = data_fail_q;
    assign bus.drop_cnt      = drop_cnt_q;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    logic [NUM_EP-1:0] pending;
    logic [NUM_EP-1:0] pending_nxt;
    logic              granted;
    logic [3:0]        gnt;
    logic [3:0]        rr;
    logic [NUM_EP-1:0] gnt_oh;
    logic [NUM_EP-1:0] eligible;
    logic [NUM_EP-1:0] pick_oh;
    logic [3:0]        pick;
    logic [3:0]        rr_nxt;
    logic              grant_now;
    logic              start_stop_q;
    logic [NUM_EP-1:0] tx_fail_q;
    logic [7:0]        tx_data_mux;

    // Round-robin pick: eligible channel with the smallest distance from rr.
    // A channel pulsing this cycle is not eligible, so a cancelling second
    // pulse always wins over a simultaneous grant.
    always_comb begin
        int best_d;
        int d;
        best_d   = NUM_EP;
        d        = 0;
        pick     = '0;
        gnt_oh   = '0;
        eligible = pending & ~bus.ep_tx_start_stop;
        for (int j = 0; j < NUM_EP; j++) begin
            gnt_oh[j] = (gnt == 4'(j));
            d = (j + NUM_EP - int'(rr)) % NUM_EP;
            if (eligible[j] && d < best_d) begin
                best_d = d;
                pick   = 4'(j);
            end
        end
        grant_now = !granted && (eligible != '0);
        rr_nxt    = (32'(pick) + 32'd1 == 32'(NUM_EP)) ? 4'd0 : pick + 4'd1;
    end

    // Pending bookkeeping: pulses toggle requests on non-granted channels,
    // and the channel receiving a grant drops its request.
    always_comb begin
        pick_oh = '0;
        for (int j = 0; j < NUM_EP; j++)
            pick_oh[j] = grant_now && (pick == 4'(j));
        pending_nxt = (pending ^ (bus.ep_tx_start_stop & ~(granted ? gnt_oh : '0))) & ~pick_oh;
    end

    // Grant lifecycle: start pulse on grant, stop forward or fail report on release.
    always_ff @(posedge USB_CLKIN or negedge NRST) begin
        if (!NRST) begin
            pending      <= '0;
            granted      <= 1'b0;
            gnt          <= '0;
            rr           <= '0;
            start_stop_q <= 1'b0;
            tx_fail_q    <= '0;
        end else begin
            start_stop_q <= 1'b0;
            tx_fail_q    <= '0;
            pending      <= pending_nxt;
            if (granted) begin
                if (bus.ulpi_tx_fail) begin
                    tx_fail_q <= gnt_oh;
                    granted   <= 1'b0;
                end else if ((bus.ep_tx_start_stop & gnt_oh) != '0) begin
                    start_stop_q <= 1'b1;
                    granted      <= 1'b0;
                end
            end else if (grant_now) begin
                granted      <= 1'b1;
                gnt          <= pick;
                rr           <= rr_nxt;
                start_stop_q <= 1'b1;
            end
        end
    end

    // Byte mux from the granted channel; zero when nothing is granted.
    always_comb begin
        tx_data_mux = '0;
        for (int j = 0; j < NUM_EP; j++)
            if (granted && gnt_oh[j])
                tx_data_mux = bus.ep_tx_data[8*j +: 8];
    end

    assign bus.ulpi_tx_start_stop = start_stop_q;
    assign bus.ulpi_tx_data       = tx_data_mux;
    assign bus.ep_tx_strb         = granted ? (gnt_oh & {NUM_EP{bus.ulpi_tx_strb}}) : '0;
    assign bus.ep_tx_fail         = tx_fail_q;

endmodule

// File: tb/tb_usb_ep_multiplexer.sv
// Directed bench for usb_ep_multiplexer: RX routing, drop counting,
// token timeout, TX round-robin, TX fail and asynchronous reset.
module tb_usb_ep_multiplexer;

    localparam int NUM_EP = 4;
    localparam int TOUT   = 8;
    localparam int CNT_W  = 16;

    logic clk;
    logic nrst;
    int   n_chk;
    int   n_err;

    usb_ep_multiplexer_if #(.NUM_EP(NUM_EP), .CNT_W(CNT_W)) bus ();

    usb_ep_multiplexer #(.NUM_EP(NUM_EP), .TOKEN_TIMEOUT(TOUT), .CNT_W(CNT_W)) dut (
        .USB_CLKIN(clk),
        .NRST     (nrst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk_token(input logic [6:0] addr, input logic [3:0] endp, input logic [7:0] pid);
        return {5'h00, endp, addr, pid};
    endfunction

    task automatic send_token(input logic [23:0] tok);
        bus.rx_token      = tok;
        bus.rx_token_strb = 1'b1;
        tick();
        bus.rx_token_strb = 1'b0;
    endtask

    // Serve one granted channel: first cycle of the grant, one byte, then stop.
    task automatic tx_serve(input int ch);
        logic [3:0] oh;
        oh = 4'(1 << ch);
        chk("tx_start", 32'(bus.ulpi_tx_start_stop), 32'd1);
        bus.ulpi_tx_strb = 1'b1;
        #1;
        chk("tx_strb_gnt", 32'(bus.ep_tx_strb), 32'(oh));
        chk("tx_data_gnt", 32'(bus.ulpi_tx_data), 32'hA0 + 32'(ch));
        bus.ulpi_tx_strb = 1'b0;
        tick();
        chk("tx_start_once", 32'(bus.ulpi_tx_start_stop), 32'd0);
        bus.ep_tx_start_stop = oh;
        tick();
        bus.ep_tx_start_stop = '0;
        chk("tx_stop", 32'(bus.ulpi_tx_start_stop), 32'd1);
        bus.ulpi_tx_strb = 1'b1;
        #1;
        chk("tx_strb_idle", 32'(bus.ep_tx_strb), 32'd0);
        bus.ulpi_tx_strb = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        nrst  = 1'b0;
        bus.dev_addr         = 7'h76;
        bus.rx_token         = '0;
        bus.rx_token_strb    = 1'b0;
        bus.rx_data          = '0;
        bus.rx_data_strb     = 1'b0;
        bus.rx_data_end      = 1'b0;
        bus.rx_data_fail     = 1'b0;
        bus.rx_pid           = '0;
        bus.ep_tx_start_stop = '0;
        bus.ulpi_tx_strb     = 1'b0;
        bus.ulpi_tx_fail     = 1'b0;
        for (int i = 0; i < NUM_EP; i++)
            bus.ep_tx_data[8*i +: 8] = 8'(8'hA0 + i);

        // Reset state
        repeat (2) tick();
        chk("rst_token", 32'(bus.ep_token_strb), 32'd0);
        chk("rst_pid", 32'(bus.ep_pid), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        chk("rst_ulpi_ss", 32'(bus.ulpi_tx_start_stop), 32'd0);
        nrst = 1'b1;
        tick();

        // Matching token to ENDP 2 followed by DATA0 with bytes 1..8
        send_token(mk_token(7'h76, 4'd2, 8'h2D));
        chk("tok_strb", 32'(bus.ep_token_strb), 32'b0100);
        chk("tok_pid", 32'(bus.ep_pid), 32'h2D);
        tick();
        chk("tok_strb_once", 32'(bus.ep_token_strb), 32'd0);
        bus.rx_pid = 8'hC3;
        for (int b = 1; b <= 8; b++) begin
            bus.rx_data      = 8'(b);
            bus.rx_data_strb = 1'b1;
            tick();
            chk("rx_strb", 32'(bus.ep_data_strb), 32'b0100);
            chk("rx_byte", 32'(bus.ep_data), 32'(b));
        end
        bus.rx_data_strb = 1'b0;
        bus.rx_data_end  = 1'b1;
        tick();
        bus.rx_data_end = 1'b0;
        chk("rx_end", 32'(bus.ep_data_end), 32'b0100);
        chk("rx_strb_off", 32'(bus.ep_data_strb), 32'd0);
        chk("rx_pid_data", 32'(bus.ep_pid), 32'hC3);
        tick();
        chk("rx_end_once", 32'(bus.ep_data_end), 32'd0);
        chk("drop_none", 32'(bus.drop_cnt), 32'd0);

        // Token for another address: the data packet is dropped
        send_token(mk_token(7'h11, 4'd2, 8'h69));
        chk("foreign_tok", 32'(bus.ep_token_strb), 32'd0);
        for (int b = 0; b < 3; b++) begin
            bus.rx_data      = 8'(8'h50 + b);
            bus.rx_data_strb = 1'b1;
            tick();
            chk("foreign_strb", 32'(bus.ep_data_strb), 32'd0);
        end
        bus.rx_data_strb = 1'b0;
        bus.rx_data_end  = 1'b1;
        tick();
        bus.rx_data_end = 1'b0;
        chk("foreign_end", 32'(bus.ep_data_end), 32'd0);
        chk("drop_one", 32'(bus.drop_cnt), 32'd1);

        // Matching token to ENDP 1, then silence past the timeout
        send_token(mk_token(7'h76, 4'd1, 8'hE1));
        chk("tout_tok", 32'(bus.ep_token_strb), 32'b0010);
        repeat (TOUT + 2) tick();
        for (int b = 0; b < 2; b++) begin
            bus.rx_data      = 8'(b);
            bus.rx_data_strb = 1'b1;
            tick();
            chk("tout_strb", 32'(bus.ep_data_strb), 32'd0);
        end
        bus.rx_data_strb = 1'b0;
        bus.rx_data_fail = 1'b1;
        tick();
        bus.rx_data_fail = 1'b0;
        chk("tout_fail", 32'(bus.ep_data_fail), 32'd0);
        chk("drop_two", 32'(bus.drop_cnt), 32'd2);

        // TX: channels 0,1,3 request together, served 0 -> 1 -> 3
        bus.ep_tx_start_stop = 4'b1011;
        tick();
        bus.ep_tx_start_stop = '0;
        chk("tx_pend_no_gnt", 32'(bus.ulpi_tx_start_stop), 32'd0);
        tick();
        tx_serve(0);
        tick();
        tx_serve(1);
        tick();
        tx_serve(3);
        tick();
        chk("tx_all_done", 32'(bus.ulpi_tx_start_stop), 32'd0);

        // Second pulse while pending cancels the request
        bus.ep_tx_start_stop = 4'b0010;
        tick();
        tick();
        bus.ep_tx_start_stop = '0;
        chk("tx_cancel_a", 32'(bus.ulpi_tx_start_stop), 32'd0);
        tick();
        chk("tx_cancel_b", 32'(bus.ulpi_tx_start_stop), 32'd0);

        // Channel 2 granted, channel 0 queues, ULPI aborts mid-packet
        bus.ep_tx_start_stop = 4'b0100;
        tick();
        bus.ep_tx_start_stop = '0;
        tick();
        chk("fail_start", 32'(bus.ulpi_tx_start_stop), 32'd1);
        bus.ep_tx_start_stop = 4'b0001;
        tick();
        bus.ep_tx_start_stop = '0;
        bus.ulpi_tx_strb = 1'b1;
        #1;
        chk("fail_strb_gnt", 32'(bus.ep_tx_strb), 32'b0100);
        chk("fail_data_gnt", 32'(bus.ulpi_tx_data), 32'hA2);
        bus.ulpi_tx_strb = 1'b0;
        bus.ulpi_tx_fail = 1'b1;
        tick();
        bus.ulpi_tx_fail = 1'b0;
        chk("fail_pulse", 32'(bus.ep_tx_fail), 32'b0100);
        chk("fail_no_stop", 32'(bus.ulpi_tx_start_stop), 32'd0);
        bus.ulpi_tx_strb = 1'b1;
        #1;
        chk("fail_released", 32'(bus.ep_tx_strb), 32'd0);
        bus.ulpi_tx_strb = 1'b0;
        tick();
        chk("fail_once", 32'(bus.ep_tx_fail), 32'd0);
        chk("fail_next_gnt", 32'(bus.ulpi_tx_start_stop), 32'd1);
        chk("fail_next_data", 32'(bus.ulpi_tx_data), 32'hA0);

        // Reset while channel 0 holds the grant and ENDP 3 is receiving data
        send_token(mk_token(7'h76, 4'd3, 8'hE1));
        bus.rx_pid       = 8'h4B;
        bus.rx_data      = 8'h99;
        bus.rx_data_strb = 1'b1;
        bus.ulpi_tx_strb = 1'b1;
        tick();
        chk("prerst_rx", 32'(bus.ep_data_strb), 32'b1000);
        chk("prerst_tx", 32'(bus.ep_tx_strb), 32'b0001);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_rx_strb", 32'(bus.ep_data_strb), 32'd0);
        chk("arst_rx_data", 32'(bus.ep_data), 32'd0);
        chk("arst_pid", 32'(bus.ep_pid), 32'd0);
        chk("arst_drop", 32'(bus.drop_cnt), 32'd0);
        chk("arst_tx_strb", 32'(bus.ep_tx_strb), 32'd0);
        chk("arst_tx_data", 32'(bus.ulpi_tx_data), 32'd0);
        bus.rx_data_strb = 1'b0;
        bus.ulpi_tx_strb = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        bus.rx_data_end  = 1'b1;
        bus.ulpi_tx_fail = 1'b1;
        tick();
        bus.rx_data_end  = 1'b0;
        bus.ulpi_tx_fail = 1'b0;
        chk("post_rst_end", 32'(bus.ep_data_end), 32'd0);
        chk("post_rst_fail", 32'(bus.ep_tx_fail), 32'd0);
        chk("post_rst_ss", 32'(bus.ulpi_tx_start_stop), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
